sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Arbitrates the single-port external scan SRAM (20-bit address, 16-bit data) between two requesters: the acquisition writer, which stores converted scan words, and the Ethernet packet builder's read side, which streams them out. The block owns the SRAM control pins and runs every access with a fixed, parameterised cycle timing. It counts completed writes and raises `sram_ready_o` once a full scan is stored; this is the packet builder's `sram_ready` input.

## Interface
- `ACCESS_CYCLES`, default 2: cycles that WE_n or OE_n is held low per access. Legal range is 1..15.
- `SCAN_WORDS`, default 52: completed writes needed before `sram_ready_o` rises.
- `clk_i`  in  1  system clock, single domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `wr_req_i`  in  1  write request. Held with its address and data until `wr_ack_o`.
- `wr_addr_i`  in  20  write address.
- `wr_data_i`  in  16  write data.
- `wr_ack_o`  out  1  one-cycle pulse marking the write as complete.
- `rd_req_i`  in  1  read request. Held with its address until `rd_valid_o`.
- `rd_addr_i`  in  20  read address.
- `rd_data_o`  out  16  registered read data. Valid while `rd_valid_o` is high, and held afterwards.
- `rd_valid_o`  out  1  one-cycle pulse marking the read as complete.
- `ready_clr_i`  in  1  clears the fill count and `sram_ready_o`.
- `sram_ready_o`  out  1  high while the fill count is at least `SCAN_WORDS`.
- `sram_addr_o`  out  20  SRAM address, registered.
- `sram_dq_o`  out  16  SRAM write data, registered.
- `sram_dq_oe_o`  out  1  data bus drive enable for the top-level tristate.
- `sram_dq_i`  in  16  SRAM read data.
- `sram_ce_n_o`, `sram_we_n_o`, `sram_oe_n_o`  out  1 each  active-low SRAM strobes, registered.

## Operation
- FSM states: IDLE, WRITE, WR_REC, READ, RD_REC.
- **IDLE:** all strobes are high and the bus is not driven.
  - Only `wr_req_i` high: go to WRITE.
  - Only `rd_req_i` high: go to READ.
  - Both high: grant the requester that was not served last, tracked by a `last_was_write` flag. After reset the flag favours the write.
  - On the grant edge, register the address (and data for a write) into the `sram_*` outputs.
- **WRITE:** CE_n=0, WE_n=0, `sram_dq_oe_o`=1, held for `ACCESS_CYCLES` cycles using a down-counter. Then go to WR_REC.
- **WR_REC:** WE_n=1, CE_n=0, bus still driven (gives data hold time); `wr_ack_o`=1; fill count increments. Then go to IDLE.
- **READ:** CE_n=0, OE_n=0, bus not driven, held for `ACCESS_CYCLES` cycles. `sram_dq_i` is sampled into `rd_data_o` on the last READ cycle. Then go to RD_REC.
- **RD_REC:** OE_n=1, CE_n=1, `rd_valid_o`=1. Then go to IDLE.
- The bus is never driven while OE_n is low. `sram_dq_oe_o` is 0 in READ, RD_REC and IDLE.
- **Fill count:** 16 bits, saturates at 0xFFFF. `sram_ready_o` = (count >= `SCAN_WORDS`), registered.
- **`ready_clr_i`:** sets the count to 0. If `ready_clr_i` coincides with `wr_ack_o`, the count becomes 1.
- Requests dropped mid-access are ignored; the access completes and its ack or valid still pulses.
- Address and data are sampled only at the grant; later changes to the inputs have no effect on the access in progress.

## Timing
- Reset values:
  - all strobes 1, `sram_dq_oe_o` 0
  - `sram_addr_o`, `sram_dq_o` and `rd_data_o` all 0
  - `wr_ack_o`, `rd_valid_o` and `sram_ready_o` all 0
  - fill count 0, FSM in IDLE, `last_was_write` 0
- Request latency: a request sampled in IDLE at edge N produces its ack or valid in cycle N+1+`ACCESS_CYCLES`.
- Back-to-back accesses take `ACCESS_CYCLES`+2 cycles each (IDLE, access, recovery). With both requesters continuously asserted, grants strictly alternate.
- Reset mid-access: strobes go high and the bus is released in the cycle after the reset edge. No ack or valid is issued for the aborted access.
- `sram_ready_o` rises one cycle after the `wr_ack_o` that brings the count to `SCAN_WORDS`.

## Structure
- Package `sram_arb_pkg` holds:
  - the FSM state enum
  - `SRAM_AW`=20, `SRAM_DW`=16
  - the default `SCAN_WORDS` and `ACCESS_CYCLES` values
- Sub-module `sram_access_timer`: a loadable down-counter with a `done` output, used for the WRITE/READ dwell. Everything else stays in the top module.

## Test plan
- Single write, addr 0x00010, data 0xA5A5, `ACCESS_CYCLES`=2 → WE_n low for exactly 2 cycles, bus driven for 3 cycles, `wr_ack_o` in cycle N+3, count = 1.
- Single read from addr 0x00010, with the SRAM model returning 0xA5A5 → OE_n low for 2 cycles, `rd_valid_o` in cycle N+3 with `rd_data_o`=0xA5A5, `sram_dq_oe_o` never 1.
- Both requests held continuously for 8 grants → order W,R,W,R,W,R,W,R, each 4 cycles apart.
- 52 writes → `sram_ready_o` rises the cycle after the 52nd ack. `ready_clr_i` coinciding with the 53rd ack → count = 1, `sram_ready_o` = 0.
- `rst_i` asserted in the second WRITE cycle → all strobes high and `dq_oe` 0 in the next cycle, no `wr_ack_o`, count = 0.
- `ACCESS_CYCLES`=1 with back-to-back writes → one ack every 3 cycles, and WE_n never low two cycles in a row.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared widths, defaults and FSM state type for the scan SRAM port arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_AW               = 20;
    localparam int unsigned SRAM_DW               = 16;
    localparam int unsigned DEFAULT_SCAN_WORDS    = 52;
    localparam int unsigned DEFAULT_ACCESS_CYCLES = 2;
    localparam int unsigned TIMER_W               = 4;
    localparam int unsigned FILL_W                = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWrRec,
        StRead,
        StRdRec
    } arb_state_e;

endpackage

// File: rtl/sram_access_timer.sv
// Loadable down-counter timing the strobe dwell of one SRAM access.
module sram_access_timer
    import sram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-port scan SRAM between the acquisition writer and the packet reader,
// and flags the packet builder once a full scan has been stored.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
    parameter int unsigned SCAN_WORDS    = DEFAULT_SCAN_WORDS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_req_i,
    input  logic [SRAM_AW-1:0] wr_addr_i,
    input  logic [SRAM_DW-1:0] wr_data_i,
    output logic               wr_ack_o,
    input  logic               rd_req_i,
    input  logic [SRAM_AW-1:0] rd_addr_i,
    output logic [SRAM_DW-1:0] rd_data_o,
    output logic               rd_valid_o,
    input  logic               ready_clr_i,
    output logic               sram_ready_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe_o,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_ce_n_o,
    output logic               sram_we_n_o,
    output logic               sram_oe_n_o
);

    // Timer is loaded on the grant edge, so it counts the remaining dwell cycles.
    localparam logic [TIMER_W-1:0] DwellLoad = TIMER_W'(ACCESS_CYCLES - 1);

    arb_state_e         state_q;
    logic               last_was_write_q;
    logic               grant_write;
    logic               grant_read;
    logic               timer_done;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic               ready_q;
    logic               wr_ack_q;
    logic               rd_valid_q;
    logic [SRAM_DW-1:0] rd_data_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [SRAM_DW-1:0] dq_q;
    logic               dq_oe_q;
    logic               ce_n_q;
    logic               we_n_q;
    logic               oe_n_q;

    always_comb begin
        grant_write = 1'b0;
        grant_read  = 1'b0;
        if (state_q == StIdle) begin
            if (wr_req_i && rd_req_i) begin
                grant_write = !last_was_write_q;
                grant_read  = last_was_write_q;
            end else begin
                grant_write = wr_req_i;
                grant_read  = rd_req_i;
            end
        end
    end

    sram_access_timer u_timer (
        .clk        (clk_i),
        .rst        (rst_i),
        .load       (grant_write | grant_read),
        .load_value (DwellLoad),
        .done       (timer_done)
    );

    // The count moves at the end of the ack cycle so a coincident clear still keeps that write.
    always_comb begin
        fill_d = fill_q;
        if (ready_clr_i) begin
            fill_d = (state_q == StWrRec) ? FILL_W'(1) : '0;
        end else if (state_q == StWrRec && fill_q != '1) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            last_was_write_q <= 1'b0;
            fill_q           <= '0;
            ready_q          <= 1'b0;
            wr_ack_q         <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= '0;
            addr_q           <= '0;
            dq_q             <= '0;
            dq_oe_q          <= 1'b0;
            ce_n_q           <= 1'b1;
            we_n_q           <= 1'b1;
            oe_n_q           <= 1'b1;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            fill_q     <= fill_d;
            ready_q    <= (32'(fill_d) >= SCAN_WORDS);
            case (state_q)
                StIdle: begin
                    if (grant_write) begin
                        state_q          <= StWrite;
                        last_was_write_q <= 1'b1;
                        addr_q           <= wr_addr_i;
                        dq_q             <= wr_data_i;
                        ce_n_q           <= 1'b0;
                        we_n_q           <= 1'b0;
                        dq_oe_q          <= 1'b1;
                    end else if (grant_read) begin
                        state_q          <= StRead;
                        last_was_write_q <= 1'b0;
                        addr_q           <= rd_addr_i;
                        ce_n_q           <= 1'b0;
                        oe_n_q           <= 1'b0;
                    end
                end
                StWrite: begin
                    if (timer_done) begin
                        state_q  <= StWrRec;
                        we_n_q   <= 1'b1;
                        wr_ack_q <= 1'b1;
                    end
                end
                StWrRec: begin
                    // Bus stays driven through recovery for data hold, released here.
                    state_q <= StIdle;
                    ce_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
                StRead: begin
                    if (timer_done) begin
                        state_q    <= StRdRec;
                        oe_n_q     <= 1'b1;
                        ce_n_q     <= 1'b1;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= sram_dq_i;
                    end
                end
                StRdRec: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    dq_oe_q <= 1'b0;
                    ce_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ack_o     = wr_ack_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign sram_ready_o = ready_q;
    assign sram_addr_o  = addr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized bench for sram_port_arbiter with an SRAM responder and memory model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int unsigned ACA = 2;
    localparam int unsigned SW  = 52;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0, rd_req = 1'b0, ready_clr = 1'b0;
    logic [19:0] wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack, rd_valid, sram_ready, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;
    logic [15:0] rd_data, sram_dq, sram_dq_in = '0;
    logic [19:0] sram_addr;

    logic        b_wr_req = 1'b0;
    logic [19:0] b_wr_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic        b_wr_ack, b_rd_valid, b_ready, b_dq_oe, b_ce_n, b_we_n, b_oe_n;
    logic [15:0] b_rd_data, b_dq;
    logic [19:0] b_addr;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ACCESS_CYCLES(ACA), .SCAN_WORDS(SW)) dut_a (
        .clk_i(clk), .rst_i(rst), .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_ack_o(wr_ack), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_valid_o(rd_valid), .ready_clr_i(ready_clr), .sram_ready_o(sram_ready),
        .sram_addr_o(sram_addr), .sram_dq_o(sram_dq), .sram_dq_oe_o(sram_dq_oe),
        .sram_dq_i(sram_dq_in), .sram_ce_n_o(sram_ce_n), .sram_we_n_o(sram_we_n),
        .sram_oe_n_o(sram_oe_n)
    );

    sram_port_arbiter #(.ACCESS_CYCLES(1), .SCAN_WORDS(SW)) dut_b (
        .clk_i(clk), .rst_i(rst), .wr_req_i(b_wr_req), .wr_addr_i(b_wr_addr),
        .wr_data_i(b_wr_data), .wr_ack_o(b_wr_ack), .rd_req_i(1'b0), .rd_addr_i(20'h0),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .ready_clr_i(1'b0),
        .sram_ready_o(b_ready), .sram_addr_o(b_addr), .sram_dq_o(b_dq), .sram_dq_oe_o(b_dq_oe),
        .sram_dq_i(16'h0), .sram_ce_n_o(b_ce_n), .sram_we_n_o(b_we_n), .sram_oe_n_o(b_oe_n)
    );

    int vectors = 0;
    int miscompares = 0;
    int bus_conflicts = 0;
    int unsigned fill_model = 0;
    bit lww_model = 1'b0;
    logic [15:0] sram_mem [logic [19:0]];
    logic [15:0] exp_mem [logic [19:0]];
    logic [19:0] pool [4];

    // SRAM responder: stores on WE_n low, returns data while OE_n low, garbage otherwise.
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq;
        if (!sram_ce_n && !sram_oe_n)
            sram_dq_in = sram_mem.exists(sram_addr) ? sram_mem[sram_addr]
                                                    : (sram_addr[15:0] ^ 16'h5A5A);
        else
            sram_dq_in = 16'hDEAD;
        if (!sram_oe_n && sram_dq_oe) bus_conflicts++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [19:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return exp_mem.exists(a) ? exp_mem[a] : (lo ^ 16'h5A5A);
    endfunction

    function automatic int unsigned fill_inc(input int unsigned f);
        return (f < 32'hFFFF) ? f + 1 : f;
    endfunction

    task automatic run_write(input logic [19:0] a, input logic [15:0] d, input bit clr_at_ack);
        int ticks = 0, we_low = 0, drv = 0;
        bit seen = 1'b0;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        while (!seen && ticks < 40) begin
            tick(); ticks++;
            if (!sram_we_n) we_low++;
            if (sram_dq_oe) drv++;
            if (wr_ack) seen = 1'b1;
        end
        wr_req = 1'b0;
        check("wr_ack_seen", 32'(seen), 32'd1);
        check("wr_latency", 32'(ticks), ACA + 1);
        check("we_low_cycles", 32'(we_low), ACA);
        check("wr_rec_we_high", 32'(sram_we_n), 32'd1);
        check("ready_at_ack", 32'(sram_ready), 32'(fill_model >= SW));
        fill_model = clr_at_ack ? 1 : fill_inc(fill_model);
        exp_mem[a] = d;
        lww_model = 1'b1;
        if (clr_at_ack) ready_clr = 1'b1;
        tick();
        ready_clr = 1'b0;
        if (sram_dq_oe) drv++;
        check("bus_drive_cycles", 32'(drv), ACA + 1);
        check("ready_after_ack", 32'(sram_ready), 32'(fill_model >= SW));
        check("fill_count", 32'(dut_a.fill_q), fill_model);
        check("wr_ack_pulse", 32'(wr_ack), 32'd0);
    endtask

    task automatic run_read(input logic [19:0] a);
        int ticks = 0, oe_low = 0, drv = 0;
        bit seen = 1'b0;
        logic [15:0] expv;
        expv = exp_read(a);
        rd_addr = a; rd_req = 1'b1;
        while (!seen && ticks < 40) begin
            tick(); ticks++;
            if (!sram_oe_n) oe_low++;
            if (sram_dq_oe) drv++;
            if (rd_valid) seen = 1'b1;
        end
        rd_req = 1'b0;
        check("rd_valid_seen", 32'(seen), 32'd1);
        check("rd_latency", 32'(ticks), ACA + 1);
        check("oe_low_cycles", 32'(oe_low), ACA);
        check("rd_bus_driven", 32'(drv), 32'd0);
        check("rd_data", 32'(rd_data), 32'(expv));
        check("rd_rec_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        lww_model = 1'b0;
        tick();
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);
        check("rd_data_held", 32'(rd_data), 32'(expv));
    endtask

    initial begin
        int ticks, acks, last_ack, runs, wi, ri;
        bit prev_low, first_w;
        logic [19:0] waddr [4];
        logic [15:0] wdata [4];
        bit order [$];
        int stamps [$];
        logic [19:0] a;
        logic [15:0] d;

        // Reset state
        tick(); tick();
        check("rst_strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'd7);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq", 32'(sram_dq), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_pulses", {30'd0, wr_ack, rd_valid}, 32'd0);
        check("rst_ready", 32'(sram_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", 32'(sram_ready), 32'd0);

        // ACCESS_CYCLES=1 back-to-back writes
        b_wr_addr = 20'h00042; b_wr_data = 16'h1234; b_wr_req = 1'b1;
        ticks = 0; acks = 0; last_ack = 0; runs = 0; prev_low = 1'b0;
        while (acks < 5 && ticks < 60) begin
            tick(); ticks++;
            if (!b_we_n && prev_low) runs++;
            prev_low = !b_we_n;
            if (b_wr_ack) begin
                if (acks == 0) check("b_first_latency", 32'(ticks), 32'd2);
                else check("b_ack_spacing", 32'(ticks - last_ack), 32'd3);
                last_ack = ticks;
                acks++;
                if (acks == 5) b_wr_req = 1'b0;
            end
        end
        check("b_ack_count", 32'(acks), 32'd5);
        check("b_we_consecutive", 32'(runs), 32'd0);
        tick(); tick();

        // Single write then read-back
        run_write(20'h00010, 16'hA5A5, 1'b0);
        run_read(20'h00010);

        // Both requesters held: grants alternate, ACCESS_CYCLES+2 apart
        for (int i = 0; i < 4; i++) begin
            waddr[i] = 20'h80000 | 20'($urandom_range(0, 20'h7FFFF));
            wdata[i] = 16'($urandom);
        end
        first_w = !lww_model;
        wi = 0; ri = 0; ticks = 0;
        wr_addr = waddr[0]; wr_data = wdata[0]; rd_addr = waddr[0];
        wr_req = 1'b1; rd_req = 1'b1;
        while (wi + ri < 8 && ticks < 80) begin
            tick(); ticks++;
            if (wr_ack) begin
                order.push_back(1'b1); stamps.push_back(ticks);
                exp_mem[waddr[wi]] = wdata[wi];
                fill_model = fill_inc(fill_model);
                wi++;
                if (wi < 4) begin wr_addr = waddr[wi]; wr_data = wdata[wi]; end
                else wr_req = 1'b0;
            end
            if (rd_valid) begin
                check("alt_rd_data", 32'(rd_data), 32'(exp_read(waddr[ri])));
                order.push_back(1'b0); stamps.push_back(ticks);
                ri++;
                if (ri < 4) rd_addr = waddr[ri];
                else rd_req = 1'b0;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check("alt_events", 32'(order.size()), 32'd8);
        for (int k = 0; k < order.size(); k++) begin
            check("alt_order", 32'(order[k]), 32'((k % 2 == 0) ? first_w : !first_w));
            if (k > 0) check("alt_spacing", 32'(stamps[k] - stamps[k-1]), ACA + 2);
        end
        lww_model = 1'b0;
        tick();
        check("alt_fill", 32'(dut_a.fill_q), fill_model);

        // Request dropped and inputs changed after the grant
        a = 20'h80123; d = 16'h5AC3;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        tick();
        check("drop_we_low", 32'(sram_we_n), 32'd0);
        wr_req = 1'b0; wr_addr = ~a; wr_data = ~d;
        ticks = 1;
        while (!wr_ack && ticks < 40) begin tick(); ticks++; end
        check("drop_ack_latency", 32'(ticks), ACA + 1);
        check("drop_addr_kept", 32'(sram_addr), 32'(a));
        check("drop_data_kept", 32'(sram_dq), 32'(d));
        exp_mem[a] = d; fill_model = fill_inc(fill_model); lww_model = 1'b1;
        tick();
        run_read(a);

        // Randomized single accesses over a small address pool
        for (int i = 0; i < 4; i++) pool[i] = 20'h80000 | 20'($urandom_range(0, 20'h7FFFF));
        for (int i = 0; i < 16; i++) begin
            a = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) run_write(a, 16'($urandom), 1'b0);
            else run_read(a);
        end

        // Fill to SCAN_WORDS, then clear coinciding with the next ack
        while (fill_model < SW) run_write(20'h80000 | 20'($urandom_range(0, 255)), 16'($urandom), 1'b0);
        check("full_ready", 32'(sram_ready), 32'd1);
        check("full_fill", 32'(dut_a.fill_q), SW);
        run_write(20'h80100, 16'hBEEF, 1'b1);
        check("clr_fill_one", 32'(dut_a.fill_q), 32'd1);
        check("clr_ready_low", 32'(sram_ready), 32'd0);

        // Reset during the second WRITE cycle
        wr_addr = 20'h00ABC; wr_data = 16'h0F0F; wr_req = 1'b1;
        tick(); tick();
        check("abort_in_write", 32'(sram_we_n), 32'd0);
        rst = 1'b1; wr_req = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'd7);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (wr_ack) acks++;
            tick();
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        fill_model = 0; lww_model = 1'b0;
        check("abort_fill", 32'(dut_a.fill_q), 32'd0);
        check("abort_ready", 32'(sram_ready), 32'd0);
        run_write(20'h80200, 16'hC0DE, 1'b0);
        run_read(20'h80200);

        check("bus_conflicts", 32'(bus_conflicts), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
